eeg_pea_eng_din_gen: RTL
========================

Name: eeg_pea_eng_din_gen

Overview:
- Feeder on the transmit side of a PE's DIN stream.
- Fetches activations from ARAM through a 1-cycle-latency synchronous read port and holds a small weight register file.
- Emits (activation, weight, weight index, activation address) tuples with valid/ready handshake and LST flags, in the order the PE accumulates.
- Optionally skips zero weights so the PE sees only non-zero taps.

Parameters:
- DATA_ACT_DW, 8, activation width.
- DATA_WEI_DW, 8, weight width (signed).
- ARAM_ADD_AW, 10, ARAM address width; also the ACT_ADD width.
- CONV_WEI_DW, 3, weight index width; register file depth is 2**CONV_WEI_DW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- CFG_START  in  1  start pulse; accepted only in IDLE.
- CFG_ACT_BASE  in  ARAM_ADD_AW  ARAM base address, latched at start.
- CFG_ACT_LEN  in  ARAM_ADD_AW+1  number of activations, latched at start.
- CFG_CONV_WEI  in  CONV_WEI_DW  number of taps (1..2**CONV_WEI_DW-1), latched at start.
- CFG_WEI_SKP  in  1  1 = skip zero weights, latched at start.
- WEI_LD_VLD  in  1  weight load strobe.
- WEI_LD_IDX  in  CONV_WEI_DW  weight load index.
- WEI_LD_DAT  in  DATA_WEI_DW  weight load data.
- IS_IDLE  out  1  FSM in IDLE.
- DONE  out  1  one-cycle pulse at end of run.
- ARAM_REN  out  1  ARAM read enable.
- ARAM_ADD  out  ARAM_ADD_AW  ARAM read address.
- ARAM_DAT  in  DATA_ACT_DW  read data, valid the cycle after ARAM_REN.
- DIN_VLD  out  1  tuple valid.
- DIN_RDY  in  1  PE ready.
- ACT_LST  out  1  last activation.
- WEI_LST  out  1  last emitted tap of the current activation.
- ACT_DAT  out  DATA_ACT_DW  activation.
- ACT_ADD  out  ARAM_ADD_AW  relative activation index 0..LEN-1.
- WEI_DAT  out  DATA_WEI_DW  weight.
- WEI_IDX  out  CONV_WEI_DW  tap index.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - IS_IDLE=1; DONE=0; ARAM_REN=0; ARAM_ADD=0; DIN_VLD=0; ACT_LST=0; WEI_LST=0; ACT_DAT=0; ACT_ADD=0; WEI_DAT=0; WEI_IDX=0.
  - Weight file cleared to 0; activation buffer emptied.
  - Reset mid-run aborts immediately; no DONE is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE->RUN on CFG_START with CFG_ACT_LEN!=0.
  - IDLE->FIN on CFG_START with CFG_ACT_LEN==0. No fetch and no emission occur.
  - RUN->FIN on the handshake (DIN_VLD&DIN_RDY) of a tuple with ACT_LST&WEI_LST.
  - FIN->IDLE unconditionally; DONE=1 in FIN only.
  - CFG_START outside IDLE is ignored.
- Weight load:
  - WEI_LD_VLD writes the file only in IDLE; ignored otherwise.
  - A load in the same cycle as CFG_START is written, but the run uses the pre-write contents.
- Tap set at start:
  - When CFG_WEI_SKP=1, the emitted taps are the indices k<CFG_CONV_WEI with wei[k]!=0.
  - When CFG_WEI_SKP=0, the emitted taps are all indices k<CFG_CONV_WEI.
  - If the set is empty, it becomes {0}; tap 0 is emitted even though its weight is zero.
  - wfst = lowest index in the set; wlst = highest index in the set.
- Emission order:
  - For a = 0..LEN-1: for each k in the tap set, ascending, emit ACT_DAT=act[a], ACT_ADD=a, WEI_DAT=wei[k], WEI_IDX=k.
  - WEI_LST=1 iff k==wlst.
  - ACT_LST=1 iff a==LEN-1.
- Fetch path:
  - ARAM_ADD = base + fetch count, wrapping modulo 2**ARAM_ADD_AW.
  - Activation buffer is a 2-entry FIFO. ARAM_DAT is written into it on the edge ending the cycle after ARAM_REN.
  - ARAM_REN=1 when fetch count<LEN and (occupancy + in-flight reads - pop this cycle) < 2. The buffer never overflows.
  - First ARAM_REN occurs in the cycle after CFG_START is sampled.
- Handshake:
  - DIN_VLD=1 whenever the buffer is non-empty in RUN.
  - All DIN outputs are registered and held stable while DIN_VLD&~DIN_RDY.
  - On handshake the tap pointer advances to the next set member. At wlst, the buffer entry is popped and the pointer returns to wfst.
  - DIN_VLD never depends combinationally on DIN_RDY.
- Latency and throughput:
  - Start sampled at T0; ARAM_REN in T1; data captured at the end of T2; DIN_VLD=1 in T3.
  - With DIN_RDY held at 1, one tuple per cycle with no bubbles, including when the tap set size is 1.
- Arithmetic: data is passed through unmodified; no sign extension or truncation.

Test Plan:
- Basic run: weights {3,-1,2}, WEI=3, SKP=0, LEN=2, ARAM[base=100..101]={5,7}, RDY=1 -> 6 tuples: (5,3,0),(5,-1,1),(5,2,2),(7,3,0),(7,-1,1),(7,2,2). WEI_LST on idx 2; ACT_LST on the last 3 tuples; ARAM_ADD 100,101; DIN_VLD first in T3; DONE one cycle after the last handshake.
- Zero skip: weights {0,4,0,6,0}, WEI=5, SKP=1, LEN=3 -> per activation only idx 1 (WEI_LST=0) then idx 3 (WEI_LST=1). 6 tuples total.
- All-zero weights with SKP=1: WEI=3, LEN=2 -> exactly 2 tuples, WEI_IDX=0, WEI_DAT=0, WEI_LST=1. DONE follows.
- Backpressure: WEI=1, LEN=4, DIN_RDY toggled 1,0,0,1,... -> outputs stable during stalls; no duplicated or dropped activation; ARAM_REN never drives more than 2 outstanding plus buffered entries.
- Boundaries: LEN=0 -> DONE in the cycle after start, no ARAM_REN, no DIN_VLD. Base=1023 with LEN=2 -> ARAM_ADD 1023 then 0, while ACT_ADD reads 0 then 1.
- Reset and ignored inputs: rst asserted mid-run -> next cycle all outputs at reset values, no DONE. CFG_START during RUN and WEI_LD_VLD during RUN -> ignored; emitted weights are unchanged.

Source files
------------

// File: rtl/eeg_pea_eng_din_gen.sv
// DIN stream feeder: fetches activations from ARAM and emits (activation, weight) tuples
// in PE accumulation order, optionally skipping zero-weight taps.
module eeg_pea_eng_din_gen #(
    parameter int unsigned DATA_ACT_DW = 8,
    parameter int unsigned DATA_WEI_DW = 8,
    parameter int unsigned ARAM_ADD_AW = 10,
    parameter int unsigned CONV_WEI_DW = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_start_i,
    input  logic [ARAM_ADD_AW-1:0] cfg_act_base_i,
    input  logic [ARAM_ADD_AW:0]   cfg_act_len_i,
    input  logic [CONV_WEI_DW-1:0] cfg_conv_wei_i,
    input  logic                   cfg_wei_skp_i,
    input  logic                   wei_ld_vld_i,
    input  logic [CONV_WEI_DW-1:0] wei_ld_idx_i,
    input  logic [DATA_WEI_DW-1:0] wei_ld_dat_i,
    output logic                   is_idle_o,
    output logic                   done_o,
    output logic                   aram_ren_o,
    output logic [ARAM_ADD_AW-1:0] aram_add_o,
    input  logic [DATA_ACT_DW-1:0] aram_dat_i,
    output logic                   din_vld_o,
    input  logic                   din_rdy_i,
    output logic                   act_lst_o,
    output logic                   wei_lst_o,
    output logic [DATA_ACT_DW-1:0] act_dat_o,
    output logic [ARAM_ADD_AW-1:0] act_add_o,
    output logic [DATA_WEI_DW-1:0] wei_dat_o,
    output logic [CONV_WEI_DW-1:0] wei_idx_o
);

    localparam int unsigned Depth = 2 ** CONV_WEI_DW;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e                 st_q, st_d;
    logic [DATA_WEI_DW-1:0] wei_q  [Depth];
    logic [DATA_WEI_DW-1:0] wrun_q [Depth];
    logic [Depth-1:0]       tap_q, tap_d, tap_new;
    logic [CONV_WEI_DW-1:0] wfst_q, wfst_d, wlst_q, wlst_d, ptr_q, ptr_d;
    logic [CONV_WEI_DW-1:0] fst_new, lst_new, nxt;
    logic                   found;
    logic [ARAM_ADD_AW-1:0] base_q, base_d;
    logic [ARAM_ADD_AW:0]   len_q, len_d, fcnt_q, fcnt_d, acnt_q, acnt_d;
    logic                   rd_q;
    logic [1:0]             occ_q, occ_d, occ_pop;
    logic [DATA_ACT_DW-1:0] abuf_q [2];
    logic [DATA_ACT_DW-1:0] abuf_d [2];
    logic                   hs, pop, aram_ren;
    logic [2:0]             pend;

    logic                   is_idle_q, done_q, vld_q, act_lst_q, wei_lst_q;
    logic [DATA_ACT_DW-1:0] act_dat_q;
    logic [ARAM_ADD_AW-1:0] act_add_q;
    logic [DATA_WEI_DW-1:0] wei_dat_q;
    logic [CONV_WEI_DW-1:0] wei_idx_q;

    // Tap set for a run is decided from the file contents before any same-cycle load.
    always_comb begin
        tap_new = '0;
        for (int k = 0; k < int'(Depth); k++) begin
            tap_new[k] = (CONV_WEI_DW'(k) < cfg_conv_wei_i) &&
                         (!cfg_wei_skp_i || (wei_q[k] != '0));
        end
        if (tap_new == '0) tap_new[0] = 1'b1;
        fst_new = '0;
        lst_new = '0;
        for (int k = int'(Depth) - 1; k >= 0; k--) begin
            if (tap_new[k]) fst_new = CONV_WEI_DW'(k);
        end
        for (int k = 0; k < int'(Depth); k++) begin
            if (tap_new[k]) lst_new = CONV_WEI_DW'(k);
        end
    end

    always_comb begin
        nxt   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < int'(Depth); k++) begin
            if (!found && tap_q[k] && (CONV_WEI_DW'(k) > ptr_q)) begin
                nxt   = CONV_WEI_DW'(k);
                found = 1'b1;
            end
        end
    end

    assign hs       = vld_q & din_rdy_i;
    assign pop      = hs & (ptr_q == wlst_q);
    // Buffered plus in-flight entries after this cycle's pop must leave room for one more.
    assign pend     = {1'b0, occ_q} + {2'b0, rd_q} - {2'b0, pop};
    assign aram_ren = (st_q == StRun) && (fcnt_q < len_q) && (pend < 3'd2);

    always_comb begin
        st_d   = st_q;
        tap_d  = tap_q;
        wfst_d = wfst_q;
        wlst_d = wlst_q;
        ptr_d  = ptr_q;
        base_d = base_q;
        len_d  = len_q;
        fcnt_d = fcnt_q;
        acnt_d = acnt_q;
        unique case (st_q)
            StIdle: begin
                if (cfg_start_i) begin
                    base_d = cfg_act_base_i;
                    len_d  = cfg_act_len_i;
                    tap_d  = tap_new;
                    wfst_d = fst_new;
                    wlst_d = lst_new;
                    ptr_d  = fst_new;
                    fcnt_d = '0;
                    acnt_d = '0;
                    st_d   = (cfg_act_len_i == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (aram_ren) fcnt_d = fcnt_q + 1'b1;
                if (hs) ptr_d = pop ? wfst_q : nxt;
                if (pop) acnt_d = acnt_q + 1'b1;
                if (hs && act_lst_q && wei_lst_q) st_d = StFin;
            end
            StFin:   st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    // Two-entry shift FIFO: entry 0 is always the head.
    always_comb begin
        occ_pop   = occ_q - {1'b0, pop};
        abuf_d[0] = pop ? abuf_q[1] : abuf_q[0];
        abuf_d[1] = abuf_q[1];
        if (rd_q) begin
            if (occ_pop == 2'd0) abuf_d[0] = aram_dat_i;
            else                 abuf_d[1] = aram_dat_i;
        end
        occ_d = occ_pop + {1'b0, rd_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(Depth); k++) begin
                wei_q[k]  <= '0;
                wrun_q[k] <= '0;
            end
        end else begin
            if (st_q == StIdle && wei_ld_vld_i) wei_q[wei_ld_idx_i] <= wei_ld_dat_i;
            if (st_q == StIdle && cfg_start_i) wrun_q <= wei_q;
        end
    end

    // Outputs are registered from next-state values so they hold still during a stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q      <= StIdle;
            tap_q     <= '0;
            wfst_q    <= '0;
            wlst_q    <= '0;
            ptr_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            fcnt_q    <= '0;
            acnt_q    <= '0;
            rd_q      <= 1'b0;
            occ_q     <= '0;
            abuf_q[0] <= '0;
            abuf_q[1] <= '0;
            is_idle_q <= 1'b1;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            act_lst_q <= 1'b0;
            wei_lst_q <= 1'b0;
            act_dat_q <= '0;
            act_add_q <= '0;
            wei_dat_q <= '0;
            wei_idx_q <= '0;
        end else begin
            st_q      <= st_d;
            tap_q     <= tap_d;
            wfst_q    <= wfst_d;
            wlst_q    <= wlst_d;
            ptr_q     <= ptr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            fcnt_q    <= fcnt_d;
            acnt_q    <= acnt_d;
            rd_q      <= aram_ren;
            occ_q     <= occ_d;
            abuf_q[0] <= abuf_d[0];
            abuf_q[1] <= abuf_d[1];
            is_idle_q <= (st_d == StIdle);
            done_q    <= (st_d == StFin);
            vld_q     <= (st_d == StRun) && (occ_d != '0);
            act_lst_q <= (acnt_d == len_d - 1'b1);
            wei_lst_q <= (ptr_d == wlst_d);
            act_dat_q <= abuf_d[0];
            act_add_q <= acnt_d[ARAM_ADD_AW-1:0];
            wei_dat_q <= wrun_q[ptr_d];
            wei_idx_q <= ptr_d;
        end
    end

    assign is_idle_o  = is_idle_q;
    assign done_o     = done_q;
    assign aram_ren_o = aram_ren;
    assign aram_add_o = base_q + fcnt_q[ARAM_ADD_AW-1:0];
    assign din_vld_o  = vld_q;
    assign act_lst_o  = act_lst_q;
    assign wei_lst_o  = wei_lst_q;
    assign act_dat_o  = act_dat_q;
    assign act_add_o  = act_add_q;
    assign wei_dat_o  = wei_dat_q;
    assign wei_idx_o  = wei_idx_q;

endmodule
